// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
//
// Control unit for a two-button stopwatch. It conditions two raw push buttons
// and runs a four-state FSM that drives a separate counter datapath.
//
// Build option:
//   STOPWATCH_DEBOUNCE_EN  when defined, each synchronized button passes through
//                          a debounce counter of DEBOUNCE_CYCLES stable cycles;
//                          when undefined, the synchronizer output is used as is.
//
// Parameters:
//   CLK_FREQ      clock frequency in Hz
//   DEBOUNCE_MS   debounce stability window in ms
//
// Ports:
//   clk            sole clock, rising edge
//   reset_n        synchronous active-low reset
//   btn_ss         raw start/stop button (asynchronous, active-high)
//   btn_lr         raw lap/reset button (asynchronous, active-high)
//   init_regs      counter clear command (high while IDLE)
//   count_enabled  counter advance enable (high while RUN or LAP)
//   count_sample   one-cycle capture strobe on RUN -> LAP
//   show_sample    selects sampled (1) or live (0) counter reading
//   state          current FSM state code
// -----------------------------------------------------------------------------
module stopwatch_ctrl #(
  parameter int CLK_FREQ    = 100000000,
  parameter int DEBOUNCE_MS = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_ss,
  input  logic       btn_lr,
  output logic       init_regs,
  output logic       count_enabled,
  output logic       count_sample,
  output logic       show_sample,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    LAP  = 2'b10,
    STOP = 2'b11
  } state_t;

  localparam int DEBOUNCE_CYCLES = CLK_FREQ / 1000 * DEBOUNCE_MS;
  localparam int BTN_SS = 0;
  localparam int BTN_LR = 1;

  if (DEBOUNCE_CYCLES < 1) begin : g_cfg_check
    $error("stopwatch_ctrl: DEBOUNCE_CYCLES must be at least 1");
  end

  // Both buttons are handled as one 2-bit vector: bit 0 = ss, bit 1 = lr.
  logic [1:0] btn_raw;
  logic [1:0] sync1;
  logic [1:0] sync2;
  logic [1:0] cond;    // conditioned (synchronized, optionally debounced) level
  logic [1:0] prev;    // previous conditioned level for edge detection
  logic [1:0] armed;   // button seen released since reset
  logic [1:0] fill;    // marks when sync2 holds post-reset samples
  logic [1:0] press;   // single-cycle press events

  assign btn_raw = {btn_lr, btn_ss};

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the values from before the edge regardless of order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
    end
  end

`ifdef STOPWATCH_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Counts consecutive cycles in which sync2 disagrees with the conditioned
  // level; it restarts on any agreement and never passes CNT_LAST.
  logic [CNT_W-1:0] db_cnt [2];

  // NOTE: the tiny debounce counter array is reset explicitly; a stale count
  // after reset could flip the conditioned level early.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cond <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] != cond[i]) begin
          if (db_cnt[i] == CNT_LAST) begin
            cond[i]   <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end
`else
  assign cond = sync2;
`endif

  // A button held through reset must not count as a press: events are only
  // armed once the synchronizer has refilled and shows the button released.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev  <= '0;
      armed <= '0;
      fill  <= '0;
    end else begin
      fill  <= {fill[0], 1'b1};
      prev  <= cond;
      armed <= armed | (~sync2 & {2{fill[1]}});
    end
  end

  assign press = cond & ~prev & armed;

  state_t state_q;
  state_t state_d;
  logic   init_regs_d;
  logic   count_enabled_d;
  logic   count_sample_d;
  logic   show_sample_d;

  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    // ss is tested first everywhere, so a simultaneous lr event is dropped.
    unique case (state_q)
      IDLE: if (press[BTN_SS]) state_d = RUN;
      RUN: begin
        if (press[BTN_SS])      state_d = STOP;
        else if (press[BTN_LR]) state_d = LAP;
      end
      LAP: begin
        if (press[BTN_SS])      state_d = STOP;
        else if (press[BTN_LR]) state_d = RUN;
      end
      STOP: begin
        if (press[BTN_SS])      state_d = RUN;
        else if (press[BTN_LR]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so the registered copies line
    // up with the state register on the same edge.
    init_regs_d     = (state_d == IDLE);
    count_enabled_d = (state_d == RUN) || (state_d == LAP);
    count_sample_d  = (state_q == RUN) && (state_d == LAP);
    show_sample_d   = (state_q == LAP) && (state_d == LAP);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      init_regs     <= 1'b1;
      count_enabled <= 1'b0;
      count_sample  <= 1'b0;
      show_sample   <= 1'b0;
    end else begin
      state_q       <= state_d;
      init_regs     <= init_regs_d;
      count_enabled <= count_enabled_d;
      count_sample  <= count_sample_d;
      show_sample   <= show_sample_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_ctrl
//
// Scoreboard bench for stopwatch_ctrl. The stimulus process presses buttons
// and, using a transition-table model of the stopwatch, queues each expected
// state change with the cycle it is due. A separate monitor pops the queue
// whenever the DUT state changes and checks the state, its timing and the
// decoded outputs every cycle.
// -----------------------------------------------------------------------------
module tb_stopwatch_ctrl;

`ifdef STOPWATCH_DEBOUNCE_EN
  localparam int CF   = 1000;
  localparam int DMS  = 4;
  localparam int DC   = CF / 1000 * DMS;
  localparam int LAT  = 3 + DC;
  localparam int HMIN = DC;
  localparam int GMIN = DC + 3;
`else
  localparam int CF   = 100000000;
  localparam int DMS  = 10;
  localparam int LAT  = 3;
  localparam int HMIN = 1;
  localparam int GMIN = 3;
`endif

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_LAP  = 2'b10;
  localparam logic [1:0] S_STOP = 2'b11;

  logic       clk;
  logic       reset_n;
  logic       btn_ss;
  logic       btn_lr;
  logic       init_regs;
  logic       count_enabled;
  logic       count_sample;
  logic       show_sample;
  logic [1:0] state;

  stopwatch_ctrl #(
    .CLK_FREQ   (CF),
    .DEBOUNCE_MS(DMS)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .btn_ss       (btn_ss),
    .btn_lr       (btn_lr),
    .init_regs    (init_regs),
    .count_enabled(count_enabled),
    .count_sample (count_sample),
    .show_sample  (show_sample),
    .state        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Stopwatch behaviour as a table: next state on an ss press and on an lr
  // press, indexed by the current state code.
  logic [1:0] ss_next [4] = '{S_RUN, S_STOP, S_STOP, S_RUN};
  logic [1:0] lr_next [4] = '{S_IDLE, S_LAP, S_RUN, S_IDLE};

  typedef struct {
    int         due;
    logic [1:0] st;
    logic       samp;
  } exp_t;

  exp_t       sb_q[$];
  logic [1:0] sb_state = S_IDLE;
  bit         mon_en = 1'b0;

  // Monitor ------------------------------------------------------------------
  logic [1:0] mon_state = S_IDLE;
  int         lap_age   = 0;
  logic       exp_samp;
  exp_t       mit;

  always @(negedge clk) begin
    if (!mon_en) begin
      mon_state = S_IDLE;
      lap_age   = 0;
    end else begin
      exp_samp = 1'b0;
      if (state !== mon_state) begin
        if (sb_q.size() == 0) begin
          check("unexpected_transition", 32'(state), 32'(mon_state));
          mon_state = state;
        end else begin
          mit = sb_q.pop_front();
          check("transition_state", 32'(state), 32'(mit.st));
          check("transition_cycle", 32'(cyc), 32'(mit.due));
          exp_samp  = mit.samp;
          mon_state = mit.st;
        end
        lap_age = 0;
      end else if (sb_q.size() > 0 && cyc > sb_q[0].due) begin
        mit = sb_q.pop_front();
        check("missing_transition", 32'(state), 32'(mit.st));
        mon_state = mit.st;
        lap_age   = 0;
      end
      check("init_regs",     32'(init_regs),     32'(mon_state == S_IDLE));
      check("count_enabled", 32'(count_enabled), 32'(mon_state == S_RUN || mon_state == S_LAP));
      check("count_sample",  32'(count_sample),  32'(exp_samp));
      check("show_sample",   32'(show_sample),   32'(mon_state == S_LAP && lap_age > 0));
      if (mon_state == S_LAP) lap_age++;
    end
  end

  // Stimulus -----------------------------------------------------------------
  // Drives one press of the given buttons; when 'counts' is set the model
  // decides whether it causes a transition and queues the expected result.
  task automatic press(input logic ss, input logic lr, input int hold, input int gap,
                       input bit counts);
    logic [1:0] ns;
    if (counts && (ss || lr)) begin
      ns = ss ? ss_next[sb_state] : lr_next[sb_state];
      if (ns != sb_state) begin
        sb_q.push_back('{due: cyc + LAT, st: ns, samp: (sb_state == S_RUN && ns == S_LAP)});
        sb_state = ns;
      end
    end
    btn_ss = ss;
    btn_lr = lr;
    repeat (hold) @(negedge clk);
    btn_ss = 1'b0;
    btn_lr = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    mon_en  = 1'b0;
    reset_n = 1'b0;
    repeat (n) @(negedge clk);
    check("rst_state",         32'(state),         32'(S_IDLE));
    check("rst_init_regs",     32'(init_regs),     32'd1);
    check("rst_count_enabled", 32'(count_enabled), 32'd0);
    check("rst_count_sample",  32'(count_sample),  32'd0);
    check("rst_show_sample",   32'(show_sample),   32'd0);
    sb_q.delete();
    sb_state = S_IDLE;
    reset_n  = 1'b1;
    mon_en   = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0;
    btn_ss  = 1'b1;
    btn_lr  = 1'b0;

    // Reset with start/stop held; holding on afterwards must not start it.
    do_reset(3);
    repeat (20) @(negedge clk);
    btn_ss = 1'b0;
    repeat (GMIN) @(negedge clk);

    // Full cycle: ss, lr, lr, ss, lr -> RUN, LAP, RUN, STOP, IDLE.
    press(1'b1, 1'b0, HMIN + 1, GMIN, 1'b1);
    press(1'b0, 1'b1, HMIN + 1, GMIN + 2, 1'b1);
    press(1'b0, 1'b1, HMIN,     GMIN, 1'b1);
    press(1'b1, 1'b0, HMIN,     GMIN, 1'b1);
    press(1'b0, 1'b1, HMIN + 2, GMIN, 1'b1);

    // lr ignored in IDLE, then simultaneous presses in RUN go to STOP.
    press(1'b0, 1'b1, HMIN, GMIN, 1'b1);
    press(1'b1, 1'b0, HMIN, GMIN, 1'b1);
    press(1'b1, 1'b1, HMIN, GMIN, 1'b1);
    press(1'b1, 1'b0, HMIN, GMIN, 1'b1);

    // Long hold of lr in RUN: a single LAP entry.
    press(1'b0, 1'b1, 100, GMIN, 1'b1);
    press(1'b0, 1'b1, HMIN, GMIN, 1'b1);
    press(1'b0, 1'b1, HMIN, GMIN + 3, 1'b1);

    // Reset while in LAP with the sample shown.
    do_reset(1);

`ifdef STOPWATCH_DEBOUNCE_EN
    // A pulse one cycle shorter than the window is rejected; a longer one
    // starts the stopwatch exactly once.
    press(1'b1, 1'b0, DC - 1, GMIN, 1'b0);
    press(1'b1, 1'b0, DC + 2, GMIN, 1'b1);
`endif

    // Random presses against the model.
    for (int i = 0; i < 60; i++) begin
      int r;
      r = $urandom_range(0, 9);
      press(r < 5 || r == 9, r >= 5, $urandom_range(HMIN, HMIN + 6),
            $urandom_range(GMIN, GMIN + 4), 1'b1);
    end

    repeat (LAT + 5) @(negedge clk);
    check("queue_drained", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter CLK_FREQ, default 100000000, clock frequency in Hz.
REQ-002 Parameter DEBOUNCE_MS, default 10, debounce stability window in ms; DEBOUNCE_CYCLES = CLK_FREQ/1000*DEBOUNCE_MS.
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 reset_n  input  1  reset, synchronous, active-low.
REQ-005 btn_ss  input  1  raw start/stop button, asynchronous to clk, active-high.
REQ-006 btn_lr  input  1  raw lap/reset button, asynchronous to clk, active-high.
REQ-007 init_regs  output  1  counter clear command.
REQ-008 count_enabled  output  1  counter advance enable.
REQ-009 count_sample  output  1  one-cycle capture strobe for the counter's sample registers.
REQ-010 show_sample  output  1  selects sampled (1) or live (0) counter reading.
REQ-011 state  output  2  current FSM state code.

Function
REQ-012 Each button SHALL pass through a 2-flop synchronizer before any other use.
REQ-013 A press event SHALL be a single-cycle pulse generated on the conditioned button's 0->1 transition; holding a button SHALL produce exactly one event.
REQ-014 FSM states SHALL be IDLE=2'b00, RUN=2'b01, LAP=2'b10, STOP=2'b11.
REQ-015 IDLE: ss event -> RUN; lr event ignored.
REQ-016 RUN: ss event -> STOP; lr event -> LAP.
REQ-017 LAP: ss event -> STOP; lr event -> RUN.
REQ-018 STOP: ss event -> RUN (resume, no clear); lr event -> IDLE.
REQ-019 Simultaneous ss and lr events SHALL apply the ss transition only; the lr event SHALL be discarded.
REQ-020 All outputs SHALL be registered; output values SHALL reflect the new state in the same cycle the state register updates.
REQ-021 init_regs SHALL be 1 exactly while state is IDLE.
REQ-022 count_enabled SHALL be 1 exactly while state is RUN or LAP.
REQ-023 count_sample SHALL pulse high for exactly one cycle, coincident with the cycle the state first reads LAP (RUN->LAP only), and SHALL be 0 otherwise.
REQ-024 show_sample SHALL rise one cycle after the count_sample pulse and SHALL fall in the cycle the state leaves LAP.
REQ-025 state SHALL equal the internal FSM state register.

Reset
REQ-026 reset_n=0 at a rising clk edge SHALL force state=IDLE, init_regs=1, count_enabled=0, count_sample=0, show_sample=0, and clear synchronizers, edge-detect flops and debounce counters.
REQ-027 Reset asserted mid-operation (any state, button held) SHALL take effect at that edge; a button still held when reset deasserts SHALL NOT generate an event until released and pressed again.

Configuration
REQ-028 Macro STOPWATCH_DEBOUNCE_EN defined: each synchronized button SHALL feed a debounce counter; the conditioned level SHALL change only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
REQ-029 Macro STOPWATCH_DEBOUNCE_EN undefined: the conditioned level SHALL be the synchronizer output directly; no debounce counters SHALL be instantiated; the FSM SHALL react on the 3rd rising clk edge after the first edge sampling the raw button high.
REQ-030 Debounce counter width SHALL be $clog2(DEBOUNCE_CYCLES+1) bits; the counter SHALL saturate, never wrap.

Verification
REQ-031 Reset: reset_n=0 for 3 cycles with btn_ss=1 -> state=00, init_regs=1, others 0; after release no event until btn_ss goes 0 then 1.
REQ-032 Full cycle (macro undefined): ss, lr, lr, ss, lr presses -> states 01,10,01,11,00; count_sample single pulse on entering 10; show_sample high from the next cycle until leaving 10.
REQ-033 Simultaneous: in RUN, btn_ss and btn_lr rise on the same edge -> state 11, no count_sample pulse.
REQ-034 Debounce (macro defined, CLK_FREQ=1000, DEBOUNCE_MS=4 -> 4 cycles): btn_ss pulses high 3 cycles -> no transition; high 4+ cycles -> IDLE->RUN exactly once.
REQ-035 Hold: btn_lr held high 100 cycles in RUN -> exactly one transition to LAP, one count_sample pulse.
REQ-036 Mid-operation reset in LAP -> next cycle state=00, show_sample=0, count_enabled=0, init_regs=1.
